adder_4bit_behavioral: RTL and testbench
========================================

Name: adder_4bit_behavioral

Overview:
- Unsigned ripple-free (behavioural) 4-bit adder with carry-in and carry-out.
- Combinational sum and carry outputs are valid within the same evaluation step as the inputs.
- Adds an optional registered result stage with status flags, so the block can feed clocked datapaths directly.
- Used as a leaf arithmetic primitive inside wider datapath blocks.

Parameters:
- WIDTH, 4, operand and sum width in bits. Only 4 is required to be verified; the RTL must be written width-generic.

Ports:
- clk  input  1  rising-edge clock for the registered stage only
- rst_n  input  1  asynchronous active-low reset for the registered stage
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- carry_in  input  1  carry into bit 0
- in_valid  input  1  qualifies a, b and carry_in for capture into the registered stage
- sum  output  WIDTH  combinational (a + b + carry_in) modulo 2^WIDTH
- carry_out  output  1  combinational carry out of the MSB
- sum_q  output  WIDTH  registered sum
- carry_out_q  output  1  registered carry_out
- overflow_q  output  1  registered two's-complement overflow flag
- zero_q  output  1  registered flag, set when the sum is zero
- out_valid  output  1  registered valid, aligned with the *_q outputs

Behaviour:
- Combinational path:
  - {carry_out, sum} = a + b + carry_in, computed at WIDTH+1 bits. No truncation before the carry is extracted.
  - Pure combinational logic: no dependence on clk or rst_n, and no latches.
  - Outputs settle within the same delta/timestep as any input change.
  - Range: the maximum result 15+15+1 = 31 gives sum=15 and carry_out=1. The minimum 0+0+0 gives sum=0 and carry_out=0.
- Registered stage, latency 1 cycle:
  - On a rising clk edge with in_valid=1, the stage captures sum, carry_out, overflow and zero.
    - overflow is set when a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
    - zero is set when sum is all zeros. It ignores carry_out.
  - out_valid <= in_valid every cycle.
  - When in_valid=0, the *_q data outputs hold their previous values and out_valid drops to 0 on the next edge.
- Reset:
  - When rst_n goes low, asynchronously and immediately: sum_q=0, carry_out_q=0, overflow_q=0, zero_q=0, out_valid=0.
  - Reset release is synchronised by the integrating design. The block samples normally on the first rising edge after rst_n goes high.
  - Reset asserted mid-stream discards the in-flight result. The combinational sum and carry_out are unaffected by reset.
- Back-to-back: a new operand set may be presented every cycle. There is no stall or backpressure.
- X-handling: no requirement beyond standard RTL semantics.

Decomposition:
- Shared package: the WIDTH default constant and a typedef for a WIDTH-bit operand. Nothing else.
- One natural sub-module, adder_core_comb: the pure combinational {carry_out, sum} computation plus the overflow and zero derivation.
- The top level instantiates adder_core_comb and adds the register stage.

Test Plan:
- Sweep a in 4..1 and b in 4..1, with carry_in = a%2, checking the combinational outputs 1 time unit after each change:
  - a=4, b=4, cin=0 -> sum=8, cout=0
  - a=3, b=2, cin=1 -> sum=6, cout=0
  - a=1, b=1, cin=1 -> sum=3, cout=0
- Carry boundary cases, combinational:
  - a=15, b=15, cin=1 -> sum=15, cout=1
  - a=15, b=0, cin=1 -> sum=0, cout=1
  - a=0, b=0, cin=0 -> sum=0, cout=0
- Registered path:
  - Inputs a=8, b=8, cin=0 with in_valid=1 at edge N.
  - After edge N: sum_q=0, carry_out_q=1, overflow_q=1, zero_q=1, out_valid=1.
  - Next edge with in_valid=0: out_valid=0 and data outputs held.
- Signed overflow:
  - a=7, b=1, cin=0 registered -> sum_q=8, overflow_q=1, carry_out_q=0.
  - a=9, b=9, cin=0 -> sum_q=2, carry_out_q=1, overflow_q=1.
- Async reset:
  - With out_valid=1 and sum_q=6, drop rst_n between clock edges.
  - All *_q outputs and out_valid go to 0 immediately, without waiting for a clk edge.
  - The combinational sum still tracks the inputs.
  - Release rst_n; the next valid capture resumes normally.
- Back-to-back throughput:
  - Present (2,3,0), (5,5,1), (15,1,0) on consecutive cycles with in_valid=1.
  - sum_q sequence 5, 11, 0 on consecutive cycles.
  - carry_out_q sequence 0, 0, 1.

Source files
------------

// File: rtl/adder_4bit_behavioral_pkg.sv
// Shared width constant and operand type for the 4-bit adder slice.
package adder_4bit_behavioral_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef logic [WIDTH_DEFAULT-1:0] operand_t;

endpackage

// File: rtl/adder_4bit_behavioral_core.sv
// Pure combinational add with carry-out, two's-complement overflow and zero detect.
module adder_core_comb
  import adder_4bit_behavioral_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow,
  output logic             o_zero
);

  logic [WIDTH:0] w_full;

  // Widen before adding so the carry survives into the top bit.
  assign w_full      = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_carry_in);
  assign o_sum       = w_full[WIDTH-1:0];
  assign o_carry_out = w_full[WIDTH];
  assign o_overflow  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign o_zero      = ~|o_sum;

endmodule

// File: rtl/adder_4bit_behavioral.sv
// Behavioural adder with a combinational result and a one-cycle registered result plus flags.
module adder_4bit_behavioral
  import adder_4bit_behavioral_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q,
  output logic             zero_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic             w_carry_out;
  logic             w_overflow;
  logic             w_zero;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_out_valid;

  adder_core_comb #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a        (a),
    .i_b        (b),
    .i_carry_in (carry_in),
    .o_sum      (w_sum),
    .o_carry_out(w_carry_out),
    .o_overflow (w_overflow),
    .o_zero     (w_zero)
  );

  // Data registers hold when no valid operands are presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum       <= w_sum;
        r_carry_out <= w_carry_out;
        r_overflow  <= w_overflow;
        r_zero      <= w_zero;
      end
    end
  end

  assign sum         = w_sum;
  assign carry_out   = w_carry_out;
  assign sum_q       = r_sum;
  assign carry_out_q = r_carry_out;
  assign overflow_q  = r_overflow;
  assign zero_q      = r_zero;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_adder_4bit_behavioral.sv
// Scoreboard bench for adder_4bit_behavioral: combinational checks at drive time, registered checks at output.
module tb_adder_4bit_behavioral;
  import adder_4bit_behavioral_pkg::*;

  typedef struct packed {
    operand_t sum;
    logic     cout;
    logic     ovf;
    logic     zero;
  } exp_t;

  logic     clk;
  logic     rst_n;
  operand_t a;
  operand_t b;
  logic     carry_in;
  logic     in_valid;
  operand_t sum;
  logic     carry_out;
  operand_t sum_q;
  logic     carry_out_q;
  logic     overflow_q;
  logic     zero_q;
  logic     out_valid;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  adder_4bit_behavioral #(
    .WIDTH(WIDTH_DEFAULT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .in_valid   (in_valid),
    .sum        (sum),
    .carry_out  (carry_out),
    .sum_q      (sum_q),
    .carry_out_q(carry_out_q),
    .overflow_q (overflow_q),
    .zero_q     (zero_q),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference computed with integer and signed arithmetic.
  function automatic exp_t model(input operand_t ma, input operand_t mb, input logic mc);
    exp_t e;
    int   total;
    int   sa;
    int   sb;
    int   ss;
    total  = int'(ma) + int'(mb) + int'(mc);
    sa     = (ma >= 8) ? int'(ma) - 16 : int'(ma);
    sb     = (mb >= 8) ? int'(mb) - 16 : int'(mb);
    ss     = sa + sb + int'(mc);
    e.sum  = operand_t'(total % 16);
    e.cout = (total >= 16);
    e.ovf  = (ss > 7) || (ss < -8);
    e.zero = ((total % 16) == 0);
    return e;
  endfunction

  task automatic drive(input operand_t ta, input operand_t tb_v, input logic tc, input logic tv);
    exp_t e;
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    carry_in = tc;
    in_valid = tv;
    #1;
    e = model(ta, tb_v, tc);
    check_eq("comb_sum", 32'(sum), 32'(e.sum));
    check_eq("comb_cout", 32'(carry_out), 32'(e.cout));
    if (tv) sb_q.push_back(e);
  endtask

  // Registered-output monitor: out_valid must follow the sampled in_valid, data pops the scoreboard.
  always @(posedge clk) begin
    logic v;
    exp_t e;
    v = in_valid && rst_n;
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sum_q", 32'(sum_q), 32'(e.sum));
        check_eq("carry_out_q", 32'(carry_out_q), 32'(e.cout));
        check_eq("overflow_q", 32'(overflow_q), 32'(e.ovf));
        check_eq("zero_q", 32'(zero_q), 32'(e.zero));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_sum_q", 32'(sum_q), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_zero_q", 32'(zero_q), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sweep a,b in 4..1 with carry_in = a%2.
    for (int ia = 4; ia >= 1; ia--) begin
      for (int ib = 4; ib >= 1; ib--) begin
        drive(operand_t'(ia), operand_t'(ib), 1'(ia % 2), 1'b1);
      end
    end
    drive(4'd4, 4'd4, 1'b0, 1'b0);
    check_eq("plan_4_4_0", 32'(sum), 32'd8);

    // Carry boundaries.
    drive(4'd15, 4'd15, 1'b1, 1'b1);
    check_eq("max_sum", 32'(sum), 32'd15);
    check_eq("max_cout", 32'(carry_out), 32'd1);
    drive(4'd15, 4'd0, 1'b1, 1'b1);
    check_eq("wrap_sum", 32'(sum), 32'd0);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    check_eq("min_cout", 32'(carry_out), 32'd0);

    // Registered 8+8, then an idle cycle must hold the data.
    drive(4'd8, 4'd8, 1'b0, 1'b1);
    drive(4'd1, 4'd2, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check_eq("hold_sum_q", 32'(sum_q), 32'd0);
    check_eq("hold_cout_q", 32'(carry_out_q), 32'd1);
    check_eq("hold_ovf_q", 32'(overflow_q), 32'd1);
    check_eq("hold_zero_q", 32'(zero_q), 32'd1);
    check_eq("hold_valid", 32'(out_valid), 32'd0);

    // Signed overflow cases.
    drive(4'd7, 4'd1, 1'b0, 1'b1);
    drive(4'd9, 4'd9, 1'b0, 1'b1);

    // Async reset between edges with a live result of 6.
    drive(4'd3, 4'd2, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check_eq("pre_rst_sum_q", 32'(sum_q), 32'd6);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("arst_sum_q", 32'(sum_q), 32'd0);
    check_eq("arst_cout_q", 32'(carry_out_q), 32'd0);
    check_eq("arst_ovf_q", 32'(overflow_q), 32'd0);
    check_eq("arst_zero_q", 32'(zero_q), 32'd0);
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    a = 4'd5;
    b = 4'd6;
    carry_in = 1'b0;
    #1;
    check_eq("arst_comb_sum", 32'(sum), 32'd11);
    @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;
    drive(4'd6, 4'd6, 1'b0, 1'b1);

    // Back-to-back throughput.
    drive(4'd2, 4'd3, 1'b0, 1'b1);
    drive(4'd5, 4'd5, 1'b1, 1'b1);
    drive(4'd15, 4'd1, 1'b0, 1'b1);
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
